// File: rtl/ir_nec_pkg.sv
// Shared types and constants for the NEC infrared decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: decoder FSM state enum, err_code values, nominal NEC pulse
// widths in microseconds, frame byte layout, tolerance-window helpers.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEAD_L = 3'd1,
    ST_LEAD_H = 3'd2,
    ST_BIT_L  = 3'd3,
    ST_BIT_H  = 3'd4,
    ST_STOP_L = 3'd5,
    ST_RPT_L  = 3'd6
  } state_t;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BAD_LEADER = 3'd1;
  localparam logic [2:0] ERR_BAD_BIT    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
  localparam logic [2:0] ERR_ADDR_INV   = 3'd4;
  localparam logic [2:0] ERR_CMD_INV    = 3'd5;
  localparam logic [2:0] ERR_ORPHAN_RPT = 3'd6;

  // Nominal NEC pulse widths in microseconds.
  localparam int unsigned T_LEAD_L_US = 9000;
  localparam int unsigned T_LEAD_H_US = 4500;
  localparam int unsigned T_RPT_H_US  = 2250;
  localparam int unsigned T_ONE_H_US  = 1690;
  localparam int unsigned T_MARK_US   = 560;

  localparam int unsigned WIDTH_W = 14;

  // Frame as it sits in the shift register after 32 LSB-first bits:
  // the first byte on air ends up in the low byte.
  typedef struct packed {
    logic [7:0] cmd_inv;
    logic [7:0] cmd;
    logic [7:0] addr_hi;
    logic [7:0] addr_lo;
  } frame_t;

  // Acceptance window bounds, evaluated at elaboration time.
  function automatic logic [WIDTH_W-1:0] win_lo(input int unsigned n_us, input int unsigned tol_pct);
    return WIDTH_W'((n_us * (100 - tol_pct)) / 100);
  endfunction

  function automatic logic [WIDTH_W-1:0] win_hi(input int unsigned n_us, input int unsigned tol_pct);
    return WIDTH_W'((n_us * (100 + tol_pct)) / 100);
  endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Pin conditioning and pulse measurement: 2-flop sync, edge register, 1 us tick, width counter.
// Latency: a pin edge shows up as a one-cycle rise/fall pulse 3 sys_clk cycles later.
// Backpressure: none; free-running, every edge is reported.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; infrared_in raw pin (idle high);
// rise/fall one-cycle edge pulses; us_tick 1 us strobe; width = us since the previous edge
// (saturating, reads as the full pulse width in the cycle the closing edge pulse is high).
module ir_pulse_timer
  import ir_nec_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               infrared_in,
  output logic               rise,
  output logic               fall,
  output logic               us_tick,
  output logic [WIDTH_W-1:0] width
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               pin_q, pin_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               tick;

  always_comb begin
    sync1_d = infrared_in;
    sync2_d = sync1_q;
    pin_d   = sync2_q;
    rise_d  = sync2_q & ~pin_q;
    fall_d  = ~sync2_q & pin_q;

    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + 1'b1;

    // Restart on the edge pulse; the tick landing in that same cycle already
    // belongs to the new pulse, so a pulse of N us reads back as N.
    if (rise_q || fall_q) begin
      width_d = {{(WIDTH_W-1){1'b0}}, tick};
    end else if (tick && (width_q != {WIDTH_W{1'b1}})) begin
      width_d = width_q + 1'b1;
    end else begin
      width_d = width_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      // Synchroniser resets to the idle level so releasing reset is not an edge.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      pin_q   <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pre_q   <= '0;
      width_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pin_q   <= pin_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pre_q   <= pre_d;
      width_q <= width_d;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign us_tick = tick;
  assign width   = width_q;

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: leader/bit classification, inverse checks, repeat-code window.
// Latency: strobes fire 1 cycle after the qualifying edge pulse (4 sys_clk after the pin edge).
// Backpressure: none; strobes are single-cycle and must be captured by the consumer.
//
// Ports: sys_clk/sys_rst_n clock and async active-low reset; infrared_in raw IR pin;
// addr/cmd decoded frame (updated only with frame_valid); frame_valid/repeat_valid/err
// one-cycle strobes; err_code cause held until next err; repeat_en repeat-active level;
// busy high whenever a frame is being received.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
  parameter int unsigned TOL_PCT          = 20,
  parameter int unsigned EXT_ADDR_EN      = 0,
  parameter int unsigned CHECK_CMD_INV    = 1,
  parameter int unsigned REPEAT_WINDOW_MS = 120
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        infrared_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        frame_valid,
  output logic        repeat_valid,
  output logic        repeat_en,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        busy
);

  localparam logic [WIDTH_W-1:0] LL_LO = win_lo(T_LEAD_L_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] LL_HI = win_hi(T_LEAD_L_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] LH_LO = win_lo(T_LEAD_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] LH_HI = win_hi(T_LEAD_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] RH_LO = win_lo(T_RPT_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] RH_HI = win_hi(T_RPT_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] B1_LO = win_lo(T_ONE_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] B1_HI = win_hi(T_ONE_H_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] MK_LO = win_lo(T_MARK_US, TOL_PCT);
  localparam logic [WIDTH_W-1:0] MK_HI = win_hi(T_MARK_US, TOL_PCT);

  localparam logic [15:0] WIN_LAST = 16'(REPEAT_WINDOW_MS - 1);
  localparam logic [9:0]  US_LAST  = 10'd999;

  function automatic logic in_win(input logic [WIDTH_W-1:0] w,
                                  input logic [WIDTH_W-1:0] lo,
                                  input logic [WIDTH_W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  logic               rise, fall, us_tick;
  logic [WIDTH_W-1:0] width;

  ir_pulse_timer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ)
  ) u_timer (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .infrared_in (infrared_in),
    .rise        (rise),
    .fall        (fall),
    .us_tick     (us_tick),
    .width       (width)
  );

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] sr_q, sr_d;
  frame_t      rx;

  logic        fv_q, fv_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        repeat_en_q, repeat_en_d;
  logic        win_open_q, win_open_d;
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [9:0]  us_cnt_q, us_cnt_d;

  // Decisions made by the next-state logic for the current cycle.
  logic        ev_fv, ev_rv, ev_err, shift_en, shift_bit;
  logic [2:0]  ev_code;

  assign rx = sr_q;

  // ---------------- state register ----------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  // An edge is classified before the timeout test, so a pulse closing in the
  // same cycle its width first exceeds the bound is judged as a bad pulse.
  always_comb begin
    state_d   = state_q;
    ev_fv     = 1'b0;
    ev_rv     = 1'b0;
    ev_err    = 1'b0;
    ev_code   = ERR_NONE;
    shift_en  = 1'b0;
    shift_bit = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_LEAD_L;
      end

      ST_LEAD_L: begin
        if (rise) begin
          if (in_win(width, LL_LO, LL_HI)) begin
            state_d = ST_LEAD_H;
          end else begin
            ev_err = 1'b1; ev_code = ERR_BAD_LEADER; state_d = ST_IDLE;
          end
        end else if (width > LL_HI) begin
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      ST_LEAD_H: begin
        if (fall) begin
          if (in_win(width, LH_LO, LH_HI)) begin
            state_d = ST_BIT_L;
          end else if (in_win(width, RH_LO, RH_HI)) begin
            state_d = ST_RPT_L;
          end else begin
            ev_err = 1'b1; ev_code = ERR_BAD_LEADER; state_d = ST_IDLE;
          end
        end else if (width > LH_HI) begin
          // The data-leader space is the longest legal one here.
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      ST_BIT_L: begin
        if (rise) begin
          if (in_win(width, MK_LO, MK_HI)) begin
            state_d = ST_BIT_H;
          end else begin
            ev_err = 1'b1; ev_code = ERR_BAD_BIT; state_d = ST_IDLE;
          end
        end else if (width > MK_HI) begin
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      ST_BIT_H: begin
        if (fall) begin
          if (in_win(width, MK_LO, MK_HI) || in_win(width, B1_LO, B1_HI)) begin
            shift_en  = 1'b1;
            shift_bit = in_win(width, B1_LO, B1_HI);
            state_d   = (idx_q == 5'd31) ? ST_STOP_L : ST_BIT_L;
          end else begin
            ev_err = 1'b1; ev_code = ERR_BAD_BIT; state_d = ST_IDLE;
          end
        end else if (width > B1_HI) begin
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      ST_STOP_L: begin
        if (rise) begin
          state_d = ST_IDLE;
          if (!in_win(width, MK_LO, MK_HI)) begin
            ev_err = 1'b1; ev_code = ERR_BAD_BIT;
          end else if ((EXT_ADDR_EN == 0) && (rx.addr_lo != ~rx.addr_hi)) begin
            ev_err = 1'b1; ev_code = ERR_ADDR_INV;
          end else if ((CHECK_CMD_INV != 0) && (rx.cmd != ~rx.cmd_inv)) begin
            ev_err = 1'b1; ev_code = ERR_CMD_INV;
          end else begin
            ev_fv = 1'b1;
          end
        end else if (width > MK_HI) begin
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      ST_RPT_L: begin
        if (rise) begin
          state_d = ST_IDLE;
          if (!in_win(width, MK_LO, MK_HI)) begin
            ev_err = 1'b1; ev_code = ERR_BAD_LEADER;
          end else if (win_open_q) begin
            ev_rv = 1'b1;
          end else begin
            ev_err = 1'b1; ev_code = ERR_ORPHAN_RPT;
          end
        end else if (width > MK_HI) begin
          ev_err = 1'b1; ev_code = ERR_TIMEOUT; state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- output / datapath logic ----------------
  always_comb begin
    fv_d        = ev_fv;
    rv_d        = ev_rv;
    err_d       = ev_err;
    err_code_d  = ev_err ? ev_code : err_code_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    win_open_d  = win_open_q;
    ms_cnt_d    = ms_cnt_q;
    us_cnt_d    = us_cnt_q;
    repeat_en_d = repeat_en_q;

    if ((state_q == ST_LEAD_H) && (state_d == ST_BIT_L)) begin
      idx_d = 5'd0;
    end else if (shift_en) begin
      idx_d = idx_q + 5'd1;
    end

    // LSB first: each new bit enters at the top and walks down.
    if (shift_en) sr_d = {shift_bit, sr_q[31:1]};

    if (ev_fv) begin
      addr_d = (EXT_ADDR_EN != 0) ? {rx.addr_hi, rx.addr_lo} : {8'h00, rx.addr_lo};
      cmd_d  = rx.cmd;
    end

    // A restart takes priority over expiry in the same cycle, so a repeat
    // arriving on the last tick of the window is accepted and keeps repeat_en.
    if (ev_fv || ev_rv) begin
      win_open_d = 1'b1;
      ms_cnt_d   = '0;
      us_cnt_d   = '0;
    end else if (win_open_q && us_tick) begin
      if (us_cnt_q == US_LAST) begin
        us_cnt_d = '0;
        if (ms_cnt_q == WIN_LAST) begin
          win_open_d = 1'b0;
          ms_cnt_d   = '0;
        end else begin
          ms_cnt_d = ms_cnt_q + 16'd1;
        end
      end else begin
        us_cnt_d = us_cnt_q + 10'd1;
      end
    end

    // A fresh frame is a new key press, so any repeat run ends there.
    if (ev_rv) begin
      repeat_en_d = 1'b1;
    end else if (ev_fv || !win_open_d) begin
      repeat_en_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_q       <= '0;
      sr_q        <= '0;
      fv_q        <= 1'b0;
      rv_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      addr_q      <= '0;
      cmd_q       <= '0;
      repeat_en_q <= 1'b0;
      win_open_q  <= 1'b0;
      ms_cnt_q    <= '0;
      us_cnt_q    <= '0;
    end else begin
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      fv_q        <= fv_d;
      rv_q        <= rv_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      repeat_en_q <= repeat_en_d;
      win_open_q  <= win_open_d;
      ms_cnt_q    <= ms_cnt_d;
      us_cnt_q    <= us_cnt_d;
    end
  end

  assign addr         = addr_q;
  assign cmd          = cmd_q;
  assign frame_valid  = fv_q;
  assign repeat_valid = rv_q;
  assign repeat_en    = repeat_en_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_nec_decoder.sv
`timescale 1ns/1ps
// Directed bench for ir_nec_decoder at a 1 MHz clock (one cycle per microsecond),
// with a second instance in extended-address mode sharing the same pin.
module tb_ir_nec_decoder;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        ir;

  logic [15:0] addr, addr_x;
  logic [7:0]  cmd, cmd_x;
  logic        frame_valid, repeat_valid, repeat_en, err, busy;
  logic        frame_valid_x, repeat_valid_x, repeat_en_x, err_x, busy_x;
  logic [2:0]  err_code, err_code_x;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_fv = 0, n_rv = 0, n_err = 0, n_overlap = 0, n_fv_x = 0;
  int err_cyc = 0;
  int t0, base_err, base_fv, base_rv;
  logic busy_seen;

  always #500 sys_clk = ~sys_clk;

  ir_nec_decoder #(
    .CLK_FREQ_HZ(1_000_000), .TOL_PCT(20), .EXT_ADDR_EN(0), .CHECK_CMD_INV(1), .REPEAT_WINDOW_MS(120)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .infrared_in(ir),
    .addr(addr), .cmd(cmd), .frame_valid(frame_valid), .repeat_valid(repeat_valid),
    .repeat_en(repeat_en), .err(err), .err_code(err_code), .busy(busy)
  );

  ir_nec_decoder #(
    .CLK_FREQ_HZ(1_000_000), .TOL_PCT(20), .EXT_ADDR_EN(1), .CHECK_CMD_INV(1), .REPEAT_WINDOW_MS(120)
  ) dut_x (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .infrared_in(ir),
    .addr(addr_x), .cmd(cmd_x), .frame_valid(frame_valid_x), .repeat_valid(repeat_valid_x),
    .repeat_en(repeat_en_x), .err(err_x), .err_code(err_code_x), .busy(busy_x)
  );

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (frame_valid) n_fv++;
    if (repeat_valid) n_rv++;
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (frame_valid_x) n_fv_x++;
    if ((int'(frame_valid) + int'(repeat_valid) + int'(err)) > 1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the pin to lvl for n cycles (n microseconds).
  task automatic pulse(input logic lvl, input int n);
    ir = lvl;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    pulse(1'b1, n);
  endtask

  // data = {cmd_inv, cmd, addr_hi, addr_lo}; bit 0 goes on air first.
  task automatic send_frame(input logic [31:0] data);
    pulse(1'b0, 9000);
    busy_seen = busy;
    pulse(1'b1, 4500);
    for (int i = 0; i < 32; i++) begin
      pulse(1'b0, 560);
      pulse(1'b1, data[i] ? 1690 : 560);
    end
    pulse(1'b0, 560);
    ir = 1'b1;
  endtask

  task automatic send_repeat();
    pulse(1'b0, 9000);
    pulse(1'b1, 2250);
    pulse(1'b0, 560);
    ir = 1'b1;
  endtask

  // Leader, one '1' bit whose space is h us, then the next mark; left high afterwards.
  task automatic send_partial(input int h);
    pulse(1'b0, 9000);
    pulse(1'b1, 4500);
    pulse(1'b0, 560);
    pulse(1'b1, h);
    pulse(1'b0, 560);
    ir = 1'b1;
  endtask

  initial begin
    ir = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(negedge sys_clk);

    // Reset state
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_strobes", {29'd0, frame_valid, repeat_valid, err}, 32'h0);
    check("rst_repeat_en", 32'(repeat_en), 32'h0);
    check("rst_err_code", 32'(err_code), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    sys_rst_n = 1'b1;
    idle(20);

    // Basic frame 0x99/0x66, 0x22/0xDD
    send_frame(32'hDD22_6699);
    idle(10);
    check("f1_busy_in_leader", 32'(busy_seen), 32'h1);
    check("f1_fv_count", 32'(n_fv), 32'd1);
    check("f1_err_count", 32'(n_err), 32'd0);
    check("f1_addr", 32'(addr), 32'h0099);
    check("f1_cmd", 32'(cmd), 32'h22);
    check("f1_ext_addr", 32'(addr_x), 32'h6699);
    check("f1_ext_fv_count", 32'(n_fv_x), 32'd1);
    check("f1_idle_busy", 32'(busy), 32'h0);

    // Repeat 40 ms later
    idle(40000);
    send_repeat();
    idle(10);
    check("rpt_rv_count", 32'(n_rv), 32'd1);
    check("rpt_err_count", 32'(n_err), 32'd0);
    check("rpt_repeat_en", 32'(repeat_en), 32'h1);
    check("rpt_addr_held", 32'(addr), 32'h0099);
    idle(109990);
    check("rpt_en_at_110ms", 32'(repeat_en), 32'h1);
    idle(11000);
    check("rpt_en_after_window", 32'(repeat_en), 32'h0);

    // Orphan repeat: window now closed
    send_repeat();
    idle(10);
    check("orph_err_count", 32'(n_err), 32'd1);
    check("orph_err_code", 32'(err_code), 32'd6);
    check("orph_rv_count", 32'(n_rv), 32'd1);

    // Bad cmd inverse (addr 0x12/0xED is itself valid)
    send_frame(32'hDC22_ED12);
    idle(10);
    check("cinv_err_count", 32'(n_err), 32'd2);
    check("cinv_err_code", 32'(err_code), 32'd5);
    check("cinv_fv_count", 32'(n_fv), 32'd1);
    check("cinv_addr_held", 32'(addr), 32'h0099);
    check("cinv_cmd_held", 32'(cmd), 32'h22);

    // Leader low held 12 ms -> timeout about 10.8 ms in
    ir = 1'b0;
    t0 = cyc;
    pulse(1'b0, 12000);
    ir = 1'b1;
    idle(100);
    check("tmo_err_count", 32'(n_err), 32'd3);
    check("tmo_err_code", 32'(err_code), 32'd3);
    check("tmo_latency_ok", 32'((err_cyc - t0 >= 10795) && (err_cyc - t0 <= 10815)), 32'h1);

    // A valid frame decodes after the timeout
    send_frame(32'hE11E_FB04);
    idle(10);
    check("f2_fv_count", 32'(n_fv), 32'd2);
    check("f2_addr", 32'(addr), 32'h0004);
    check("f2_cmd", 32'(cmd), 32'h1E);
    check("f2_ext_addr", 32'(addr_x), 32'hFB04);
    check("f2_err_count", 32'(n_err), 32'd3);

    // Bit-1 space tolerance: accepted widths end in a BIT_H timeout, a rejected one in BAD_BIT
    base_err = n_err;
    send_partial(1352);
    idle(2200);
    check("tol1352_err_count", 32'(n_err - base_err), 32'd1);
    check("tol1352_err_code", 32'(err_code), 32'd3);

    base_err = n_err;
    send_partial(2028);
    idle(2200);
    check("tol2028_err_count", 32'(n_err - base_err), 32'd1);
    check("tol2028_err_code", 32'(err_code), 32'd3);

    base_err = n_err;
    send_partial(1300);
    idle(2200);
    check("tol1300_err_count", 32'(n_err - base_err), 32'd1);
    check("tol1300_err_code", 32'(err_code), 32'd2);
    check("tol_fv_count", 32'(n_fv), 32'd2);

    // Reset in the middle of a frame
    base_err = n_err;
    base_fv  = n_fv;
    base_rv  = n_rv;
    pulse(1'b0, 9000);
    pulse(1'b1, 4500);
    pulse(1'b0, 560);
    pulse(1'b1, 1000);
    check("mid_busy", 32'(busy), 32'h1);
    sys_rst_n = 1'b0;
    idle(5);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_addr", 32'(addr), 32'h0);
    sys_rst_n = 1'b1;
    idle(3000);
    check("mid_err_count", 32'(n_err - base_err), 32'd0);
    check("mid_fv_count", 32'(n_fv - base_fv), 32'd0);
    check("mid_rv_count", 32'(n_rv - base_rv), 32'd0);
    check("mid_post_addr", 32'(addr), 32'h0);
    check("mid_post_cmd", 32'(cmd), 32'h0);
    check("mid_post_err_code", 32'(err_code), 32'h0);
    check("mid_post_busy", 32'(busy), 32'h0);
    check("mid_post_repeat_en", 32'(repeat_en), 32'h0);

    check("strobe_exclusive", 32'(n_overlap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
